// File: rtl/bcd_serial_deserializer.sv
// Serial-to-parallel BCD digit assembler with range check, small FIFO and a
// valid/ready output port feeding the BCD-to-2421 converter's a/b/c/d inputs.
module bcd_serial_deserializer #(
  parameter int DEPTH     = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ser_in,
  input  logic       ser_valid,
  input  logic       ser_start,
  output logic       out_a,
  output logic       out_b,
  output logic       out_c,
  output logic       out_d,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       range_err,
  output logic       ovf_err,
  output logic       frame_err,
  output logic [7:0] digit_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Handshake: a digit transfers on any rising edge where out_valid && out_ready;
  // out_a..out_d stay stable while out_valid is high and out_ready is low.

  logic [1:0]    bc_q, bc_d;
  logic [3:0]    sh_q, sh_d;
  logic [3:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    digit_cnt_q, digit_cnt_d;
  logic          range_err_q, range_err_d;
  logic          ovf_err_q, ovf_err_d;
  logic          frame_err_q, frame_err_d;

  logic [3:0] shifted;
  logic       complete, in_range, full, empty, push, pop;

  always_comb begin
    shifted     = MSB_FIRST ? {sh_q[2:0], ser_in} : {ser_in, sh_q[3:1]};
    complete    = ser_valid && !ser_start && (bc_q == 2'd3);
    in_range    = (shifted <= 4'd9);
    full        = (cnt_q == CW'(DEPTH));
    empty       = (cnt_q == '0);
    pop         = !empty && out_ready;
    // A full FIFO still accepts the new digit when the head leaves on the same edge.
    push        = complete && in_range && (!full || pop);
    range_err_d = complete && !in_range;
    ovf_err_d   = complete && in_range && full && !pop;
    frame_err_d = ser_valid && ser_start && (bc_q != 2'd0);
    cnt_d       = cnt_q + CW'(push) - CW'(pop);
    digit_cnt_d = (pop && (digit_cnt_q != 8'hFF)) ? digit_cnt_q + 8'd1 : digit_cnt_q;

    bc_d = bc_q;
    sh_d = sh_q;
    if (ser_valid) begin
      if (ser_start) begin
        bc_d = 2'd1;
        sh_d = MSB_FIRST ? {3'b000, ser_in} : {ser_in, 3'b000};
      end else begin
        bc_d = bc_q + 2'd1;
        sh_d = shifted;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bc_q        <= '0;
      sh_q        <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      digit_cnt_q <= '0;
      range_err_q <= 1'b0;
      ovf_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      bc_q        <= bc_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      digit_cnt_q <= digit_cnt_d;
      range_err_q <= range_err_d;
      ovf_err_q   <= ovf_err_d;
      frame_err_q <= frame_err_d;
      if (push) begin
        mem_q[wr_q] <= shifted;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop) rd_q <= rd_q + AW'(1);
    end
  end

  assign out_valid = !empty;
  assign {out_a, out_b, out_c, out_d} = empty ? 4'b0000 : mem_q[rd_q];
  assign range_err = range_err_q;
  assign ovf_err   = ovf_err_q;
  assign frame_err = frame_err_q;
  assign digit_cnt = digit_cnt_q;

endmodule
